// File: rtl/control_fsm_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcodes, ALU operation codes.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC     = 3'd2,
        ST_WAIT_IN  = 3'd3,
        ST_WAIT_OUT = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LDA    = 4'h1,
        OP_STA    = 4'h2,
        OP_ADD    = 4'h3,
        OP_SUB    = 4'h4,
        OP_AND    = 4'h5,
        OP_OR     = 4'h6,
        OP_NOT    = 4'h7,
        OP_JMP    = 4'h8,
        OP_JZ     = 4'h9,
        OP_JC     = 4'hA,
        OP_IN     = 4'hB,
        OP_OUT    = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_RSVD_E = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_NOT  = 3'd5
    } alu_op_t;

    function automatic alu_op_t alu_for(input opcode_t op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_NOT:  return ALU_NOT;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_wait_timer.sv
// Loadable down-counter; expired is high while the count sits at zero. Latency: load visible next cycle.
// No backpressure: dec is ignored once the count reaches zero.
module control_fsm_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer: 3 cycles per instruction plus IN/OUT wait cycles.
// Stalls in WAIT_IN on in_valid (bounded by IN_TIMEOUT) and in WAIT_OUT on out_ready (unbounded).
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int DATAW      = 8,
    parameter int OPW        = 4,
    parameter int IN_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DATAW-1:0] instr,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] ir_q,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             pc_inc,
    output logic [2:0]       alu_op,
    output logic             jump,
    output logic             jumpC,
    output logic             sin,
    output logic             InA,
    output logic             twone,
    output logic             in_ready,
    output logic             out_valid,
    output logic             in_timeout,
    output logic             halted
);

    localparam int TW = (IN_TIMEOUT > 1) ? $clog2(IN_TIMEOUT) : 1;
    // Loading N-1 makes the N-th WAIT_IN cycle the one that sees expiry.
    localparam logic [TW-1:0] TMR_LOAD = (IN_TIMEOUT > 0) ? TW'(IN_TIMEOUT - 1) : '0;

    state_t  state;
    state_t  state_nxt;
    opcode_t op;
    logic    tmr_load;
    logic    tmr_dec;
    logic    tmr_expired;
    logic    timeout_hit;
    logic    set_timeout;

    assign op          = opcode_t'(ir_q[DATAW-1 -: OPW]);
    assign timeout_hit = (IN_TIMEOUT != 0) && tmr_expired;

    control_fsm_wait_timer #(
        .W(TW)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(TMR_LOAD),
        .dec     (tmr_dec),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            ir_q       <= '0;
            in_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH) begin
                ir_q <= instr;
            end
            if (set_timeout) begin
                in_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        pc_inc      = 1'b0;
        alu_op      = ALU_PASS;
        jump        = 1'b0;
        jumpC       = 1'b0;
        sin         = 1'b0;
        InA         = 1'b0;
        twone       = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        halted      = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        set_timeout = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_rd    = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                pc_inc    = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                case (op)
                    OP_LDA: begin
                        mem_rd = 1'b1;
                        alu_op = ALU_PASS;
                        sin    = 1'b1;
                    end
                    OP_STA: mem_wr = 1'b1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        mem_rd = 1'b1;
                        alu_op = alu_for(op);
                        twone  = 1'b1;
                        sin    = 1'b1;
                    end
                    OP_NOT: begin
                        alu_op = ALU_NOT;
                        sin    = 1'b1;
                    end
                    OP_JMP: jump  = 1'b1;
                    OP_JZ:  jumpC = flag_z;
                    OP_JC:  jumpC = flag_c;
                    OP_IN: begin
                        tmr_load  = 1'b1;
                        state_nxt = ST_WAIT_IN;
                    end
                    OP_OUT: state_nxt = ST_WAIT_OUT;
                    OP_HLT: state_nxt = ST_HALT;
                    default: ;
                endcase
            end
            ST_WAIT_IN: begin
                in_ready = 1'b1;
                // Data arriving in the expiry cycle takes priority over the abort.
                if (in_valid) begin
                    InA       = 1'b1;
                    state_nxt = ST_FETCH;
                end else if (timeout_hit) begin
                    set_timeout = 1'b1;
                    state_nxt   = ST_FETCH;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WAIT_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: halted = 1'b1;
            default: state_nxt = ST_FETCH;
        endcase

        // An instruction caught by reset must not leak a strobe downstream.
        if (reset) begin
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            pc_inc    = 1'b0;
            alu_op    = ALU_PASS;
            jump      = 1'b0;
            jumpC     = 1'b0;
            sin       = 1'b0;
            InA       = 1'b0;
            twone     = 1'b0;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            halted    = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Instruction-level reference: each issued instruction expands into its expected per-cycle output
// vectors, which a single negedge compare process checks against the sequencer.
module tb_control_fsm;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       flag_z = 1'b0;
    logic       flag_c = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] ir_q;
    logic       mem_rd, mem_wr, pc_inc;
    logic [2:0] alu_op;
    logic       jump, jump_c, sin, in_a, twone;
    logic       in_ready, out_valid, in_timeout, halted;

    always #5 clk = ~clk;

    control_fsm #(
        .DATAW     (8),
        .OPW       (4),
        .IN_TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .ir_q      (ir_q),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .pc_inc    (pc_inc),
        .alu_op    (alu_op),
        .jump      (jump),
        .jumpC     (jump_c),
        .sin       (sin),
        .InA       (in_a),
        .twone     (twone),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .in_timeout(in_timeout),
        .halted    (halted)
    );

    typedef struct packed {
        logic [7:0] ir;
        logic       mem_rd;
        logic       mem_wr;
        logic       pc_inc;
        logic [2:0] alu_op;
        logic       jump;
        logic       jump_c;
        logic       sin;
        logic       ina;
        logic       twone;
        logic       in_ready;
        logic       out_valid;
        logic       in_timeout;
        logic       halted;
    } obs_t;

    obs_t       expq[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic       pins_done = 1'b0;
    logic [7:0] m_ir = 8'h00;
    logic       m_to = 1'b0;

    // Execute-cycle strobes of one opcode, straight from the instruction table.
    function automatic obs_t exec_expect(input logic [3:0] op, input logic fz, input logic fc);
        obs_t e = '0;
        case (op)
            4'h1: begin e.mem_rd = 1'b1; e.sin = 1'b1; end
            4'h2: e.mem_wr = 1'b1;
            4'h3, 4'h4, 4'h5, 4'h6: begin
                e.mem_rd = 1'b1;
                e.alu_op = 3'(op - 4'h2);
                e.twone  = 1'b1;
                e.sin    = 1'b1;
            end
            4'h7: begin e.alu_op = 3'd5; e.sin = 1'b1; end
            4'h8: e.jump = 1'b1;
            4'h9: e.jump_c = fz;
            4'hA: e.jump_c = fc;
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t base();
        obs_t e = '0;
        e.ir         = m_ir;
        e.in_timeout = m_to;
        return e;
    endfunction

    task automatic pin(input string name, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL pin_%s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin : compare
        obs_t e;
        obs_t g;
        obs_t p;
        if (!pins_done) begin
            pins_done = 1'b1;
            p = exec_expect(4'h1, 1'b0, 1'b0);
            pin("lda", 16'({p.mem_rd, p.alu_op, p.sin, p.twone}), 16'b1_000_1_0);
            p = exec_expect(4'h3, 1'b0, 1'b0);
            pin("add", 16'({p.mem_rd, p.alu_op, p.twone, p.sin, p.mem_wr, p.jump}), 16'b1_001_1_1_0_0);
            p = exec_expect(4'h2, 1'b1, 1'b1);
            pin("sta", 16'({p.mem_wr, p.mem_rd, p.sin, p.jump, p.jump_c}), 16'b1_0_0_0_0);
            p = exec_expect(4'h7, 1'b0, 1'b0);
            pin("not", 16'({p.alu_op, p.sin, p.twone, p.mem_rd}), 16'b101_1_0_0);
            p = exec_expect(4'h9, 1'b0, 1'b1);
            pin("jz_false", 16'({p.jump, p.jump_c}), 16'b00);
            p = exec_expect(4'h9, 1'b1, 1'b0);
            pin("jz_true", 16'({p.jump, p.jump_c}), 16'b01);
            p = exec_expect(4'h8, 1'b0, 1'b0);
            pin("jmp", 16'({p.jump, p.jump_c}), 16'b10);
        end
        if (expq.size() > 0) begin
            e = expq.pop_front();
            g = {ir_q, mem_rd, mem_wr, pc_inc, alu_op, jump, jump_c, sin, in_a, twone,
                 in_ready, out_valid, in_timeout, halted};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, g, e);
            end
        end
    end

    task automatic step(input logic rst, input logic [7:0] ins, input logic fz, input logic fc,
                        input logic iv, input logic ordy, input obs_t e, input logic chk);
        @(posedge clk);
        #1;
        reset     = rst;
        instr     = ins;
        flag_z    = fz;
        flag_c    = fc;
        in_valid  = iv;
        out_ready = ordy;
        if (chk) expq.push_back(e);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic do_reset();
        obs_t e = base();
        step(1'b1, 8'($urandom), rb(), rb(), rb(), rb(), e, 1'b1);
        m_ir = 8'h00;
        m_to = 1'b0;
    endtask

    // One full instruction: FETCH, DECODE, EXEC, then any wait/halt cycles it implies.
    task automatic run_instr(input logic [7:0] ins, input logic fz, input logic fc,
                             input int in_dly, input int out_dly, input int halt_cyc);
        obs_t       e;
        logic [3:0] op;
        logic       iv;
        op = ins[7:4];
        e = base();
        e.mem_rd = 1'b1;
        step(1'b0, ins, rb(), rb(), rb(), rb(), e, 1'b1);
        m_ir = ins;
        e = base();
        e.pc_inc = 1'b1;
        step(1'b0, 8'($urandom), rb(), rb(), rb(), rb(), e, 1'b1);
        e = exec_expect(op, fz, fc);
        e.ir = m_ir;
        e.in_timeout = m_to;
        step(1'b0, 8'($urandom), fz, fc, rb(), rb(), e, 1'b1);
        if (op == 4'hB) begin
            for (int k = 1; k <= TMO; k++) begin
                iv = (k > in_dly);
                e = base();
                e.in_ready = 1'b1;
                e.ina = iv;
                step(1'b0, 8'($urandom), rb(), rb(), iv, rb(), e, 1'b1);
                if (iv) break;
                if (k == TMO) m_to = 1'b1;
            end
        end else if (op == 4'hC) begin
            for (int k = 1; k <= out_dly + 1; k++) begin
                e = base();
                e.out_valid = 1'b1;
                step(1'b0, 8'($urandom), rb(), rb(), rb(), (k == out_dly + 1), e, 1'b1);
            end
        end else if (op == 4'hF) begin
            for (int k = 0; k < halt_cyc; k++) begin
                e = base();
                e.halted = 1'b1;
                step(1'b0, 8'($urandom), rb(), rb(), rb(), rb(), e, 1'b1);
            end
        end
    endtask

    task automatic run_abort(input logic [7:0] ins);
        obs_t e;
        e = base();
        e.mem_rd = 1'b1;
        step(1'b0, ins, rb(), rb(), rb(), rb(), e, 1'b1);
        m_ir = ins;
        e = base();
        e.pc_inc = 1'b1;
        step(1'b0, 8'($urandom), rb(), rb(), rb(), rb(), e, 1'b1);
        do_reset();
    endtask

    initial begin
        obs_t       none;
        int         r;
        logic [7:0] ins;
        none = '0;
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, none, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, none, 1'b0);
        m_ir = 8'h00;
        m_to = 1'b0;

        run_instr(8'h13, 1'b0, 1'b0, 0, 0, 0);
        run_instr(8'h35, 1'b0, 1'b0, 0, 0, 0);
        run_instr(8'h2A, 1'b0, 1'b0, 0, 0, 0);
        run_abort(8'h35);
        run_instr(8'h94, 1'b0, 1'b1, 0, 0, 0);
        run_instr(8'h94, 1'b1, 1'b0, 0, 0, 0);
        run_instr(8'hA7, 1'b0, 1'b1, 0, 0, 0);
        run_instr(8'h80, 1'b1, 1'b1, 0, 0, 0);
        run_instr(8'h7F, 1'b0, 1'b0, 0, 0, 0);
        run_instr(8'hB0, 1'b0, 1'b0, 4, 0, 0);
        run_instr(8'hB0, 1'b0, 1'b0, TMO - 1, 0, 0);
        run_instr(8'hB0, 1'b0, 1'b0, 1000, 0, 0);
        run_instr(8'h00, 1'b0, 1'b0, 0, 0, 0);
        run_instr(8'hC0, 1'b0, 1'b0, 0, 3, 0);
        run_instr(8'hD5, 1'b1, 1'b1, 0, 0, 0);
        run_instr(8'hF0, 1'b0, 1'b0, 0, 0, 20);
        do_reset();

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                run_abort(8'($urandom));
            end else if (r == 1) begin
                run_instr({4'hF, 4'($urandom)}, rb(), rb(), 0, 0, $urandom_range(1, 5));
                do_reset();
            end else begin
                ins = {4'($urandom_range(0, 14)), 4'($urandom)};
                run_instr(ins, rb(), rb(), $urandom_range(0, TMO + 2), $urandom_range(0, 5), 0);
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
